reg_writeback: RTL and testbench

- Write-side driver for register_file: collects result writebacks from the ALU and the load/store unit.
- Buffers results in a small in-order FIFO and issues at most one register-file write per cycle on the rd, pc and cpsr write ports.
- Exports a per-register pending mask that issue logic uses to stall reads of registers not yet written.
- Sits between execute/memory stages and register_file.

---
 rtl/reg_writeback_pkg.sv | 27 ++
 rtl/reg_writeback_fifo.sv | 74 +++++++
 rtl/reg_writeback.sv | 120 ++++++++++++
 tb/tb_reg_writeback.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared constants and the writeback entry layout used by reg_writeback,
// register_file and the benches.
package reg_writeback_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 16;

  localparam logic [ADDR_WIDTH-1:0] PC_REG = 4'd15;

  typedef struct packed {
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd;
    logic [WORD_SIZE-1:0]  data;
    logic                  cpsr_en;
    logic [WORD_SIZE-1:0]  cpsr;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [ADDR_WIDTH-1:0] r);
    reg_bit = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

  function automatic logic is_pc(input logic [ADDR_WIDTH-1:0] r);
    is_pc = (r == PC_REG);
  endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// In-order writeback queue: up to two pushes (a before b) and one pop per cycle,
// with per-slot visibility of queued register destinations.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push_a,
  input  wb_entry_t                 entry_a,
  input  logic                      push_b,
  input  wb_entry_t                 entry_b,
  input  logic                      pop,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          live,
  output logic [ADDR_WIDTH-1:0]     live_rd [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr_b;

  assign wr_ptr_b = push_a ? (wr_ptr + PW'(1)) : wr_ptr;
  assign head     = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Slot storage; the b entry lands behind the a entry when both push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (push_a && !flush) begin
        slots[wr_ptr] <= entry_a;
      end
      if (push_b && !flush) begin
        slots[wr_ptr_b] <= entry_b;
      end
    end
  end

  // A slot is occupied when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_live
    logic [PW-1:0] age;
    assign age        = PW'(g) - rd_ptr;
    assign live[g]    = ({1'b0, age} < count) && slots[g].rd_en;
    assign live_rd[g] = slots[g].rd;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write driver: queues ALU and load results in order and issues
// one registered rd/pc/cpsr write per cycle, exporting a pending-register mask.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic                  alu_rd_en,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [WORD_SIZE-1:0]  alu_data,
  input  logic                  alu_cpsr_en,
  input  logic [WORD_SIZE-1:0]  alu_cpsr,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [WORD_SIZE-1:0]  mem_data,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  cpsr_we,
  output logic [WORD_SIZE-1:0]  cpsr_in,
  output logic [NUM_REGS-1:0]   pending
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         count;
  logic                  mem_take;
  logic                  alu_take;
  logic                  alu_push;
  logic                  pop;
  wb_entry_t             mem_entry;
  wb_entry_t             alu_entry;
  wb_entry_t             head;
  logic [DEPTH-1:0]      live;
  logic [ADDR_WIDTH-1:0] live_rd [DEPTH];

  // Space is judged on the registered count only; a same-cycle pop frees nothing.
  assign mem_ready = !flush && (count < CW'(DEPTH));
  assign mem_take  = mem_valid && mem_ready;
  assign alu_ready = !flush && ((count + CW'(mem_take)) < CW'(DEPTH));
  assign alu_take  = alu_valid && alu_ready;
  assign alu_push  = alu_take && (alu_rd_en || alu_cpsr_en);
  assign pop       = !flush && (count != '0);

  assign mem_entry = '{rd_en: 1'b1, rd: mem_rd, data: mem_data,
                       cpsr_en: 1'b0, cpsr: '0};
  assign alu_entry = '{rd_en: alu_rd_en, rd: alu_rd, data: alu_data,
                       cpsr_en: alu_cpsr_en, cpsr: alu_cpsr};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push_a  (mem_take),
    .entry_a (mem_entry),
    .push_b  (alu_push),
    .entry_b (alu_entry),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .live    (live),
    .live_rd (live_rd)
  );

  // Route the popped entry onto the write ports; data registers hold when unused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_we    <= 1'b0;
      pc_we    <= 1'b0;
      cpsr_we  <= 1'b0;
      write_rd <= '0;
      rd_in    <= '0;
      pc_in    <= '0;
      cpsr_in  <= '0;
    end else if (flush) begin
      rd_we   <= 1'b0;
      pc_we   <= 1'b0;
      cpsr_we <= 1'b0;
    end else begin
      rd_we   <= 1'b0;
      pc_we   <= 1'b0;
      cpsr_we <= 1'b0;
      if (pop) begin
        if (head.rd_en && is_pc(head.rd)) begin
          pc_we <= 1'b1;
          pc_in <= head.data;
        end else if (head.rd_en) begin
          rd_we    <= 1'b1;
          write_rd <= head.rd;
          rd_in    <= head.data;
        end
        if (head.cpsr_en) begin
          cpsr_we <= 1'b1;
          cpsr_in <= head.cpsr;
        end
      end
    end
  end

  // Pending covers queued destinations plus the write currently on the ports.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending | (live[i] ? reg_bit(live_rd[i]) : '0);
    end
    pending = pending | (rd_we ? reg_bit(write_rd) : '0)
                      | (pc_we ? reg_bit(PC_REG) : '0);
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised and directed bench for reg_writeback against a queue-based model.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0, alu_rd_en = 1'b0, alu_cpsr_en = 1'b0;
  logic [3:0]  alu_rd = 4'd0;
  logic [31:0] alu_data = 32'd0, alu_cpsr = 32'd0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_rd = 4'd0;
  logic [31:0] mem_data = 32'd0;
  logic        alu_ready, mem_ready, rd_we, pc_we, cpsr_we;
  logic [3:0]  write_rd;
  logic [31:0] rd_in, pc_in, cpsr_in;
  logic [15:0] pending;

  reg_writeback #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_en(alu_rd_en),
    .alu_rd(alu_rd), .alu_data(alu_data), .alu_cpsr_en(alu_cpsr_en),
    .alu_cpsr(alu_cpsr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data), .rd_we(rd_we), .write_rd(write_rd),
    .rd_in(rd_in), .pc_we(pc_we), .pc_in(pc_in), .cpsr_we(cpsr_we),
    .cpsr_in(cpsr_in), .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  wb_entry_t   q[$];
  logic        e_rd_we = 1'b0, e_pc_we = 1'b0, e_cpsr_we = 1'b0;
  logic [3:0]  e_write_rd = 4'd0;
  logic [31:0] e_rd_in = 32'd0, e_pc_in = 32'd0, e_cpsr_in = 32'd0;
  logic        mem_acc = 1'b0, alu_acc = 1'b0, seen_alu_ready = 1'b0;

  logic [31:0] rf_dut [16];

  always @(posedge clk) begin
    if (rd_we) rf_dut[write_rd] <= rd_in;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = 16'h0;
    foreach (q[i]) if (q[i].rd_en) p[q[i].rd] = 1'b1;
    if (e_rd_we) p[e_write_rd] = 1'b1;
    if (e_pc_we) p[15] = 1'b1;
    return p;
  endfunction

  task automatic step();
    logic em_r, ea_r;
    int n;
    wb_entry_t e;
    #1;
    n = q.size();
    em_r = !flush && (n < 4);
    ea_r = !flush && ((n + ((mem_valid && em_r) ? 1 : 0)) < 4);
    check_val("mem_ready", {31'd0, mem_ready}, {31'd0, em_r});
    check_val("alu_ready", {31'd0, alu_ready}, {31'd0, ea_r});
    seen_alu_ready = alu_ready;
    mem_acc = mem_valid && em_r;
    alu_acc = alu_valid && ea_r;
    @(posedge clk);
    e_rd_we = 1'b0; e_pc_we = 1'b0; e_cpsr_we = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.rd_en && e.rd == 4'd15) begin
          e_pc_we = 1'b1; e_pc_in = e.data;
        end else if (e.rd_en) begin
          e_rd_we = 1'b1; e_write_rd = e.rd; e_rd_in = e.data;
        end
        if (e.cpsr_en) begin
          e_cpsr_we = 1'b1; e_cpsr_in = e.cpsr;
        end
      end
      if (mem_acc) begin
        e = '{rd_en: 1'b1, rd: mem_rd, data: mem_data, cpsr_en: 1'b0, cpsr: 32'h0};
        q.push_back(e);
      end
      if (alu_acc && (alu_rd_en || alu_cpsr_en)) begin
        e = '{rd_en: alu_rd_en, rd: alu_rd, data: alu_data, cpsr_en: alu_cpsr_en, cpsr: alu_cpsr};
        q.push_back(e);
      end
    end
    #1;
    check_val("rd_we", {31'd0, rd_we}, {31'd0, e_rd_we});
    check_val("write_rd", {28'd0, write_rd}, {28'd0, e_write_rd});
    check_val("rd_in", rd_in, e_rd_in);
    check_val("pc_we", {31'd0, pc_we}, {31'd0, e_pc_we});
    check_val("pc_in", pc_in, e_pc_in);
    check_val("cpsr_we", {31'd0, cpsr_we}, {31'd0, e_cpsr_we});
    check_val("cpsr_in", cpsr_in, e_cpsr_in);
    check_val("pending", {16'd0, pending}, {16'd0, model_pending()});
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0; alu_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic alu_offer(input logic [3:0] rd, input logic [31:0] d,
                           input logic cen, input logic [31:0] c);
    alu_valid = 1'b1; alu_rd_en = 1'b1; alu_rd = rd; alu_data = d;
    alu_cpsr_en = cen; alu_cpsr = c;
  endtask

  initial begin
    int mi, ai, cyc;
    logic saw_stall;

    for (int r = 0; r < 16; r++) rf_dut[r] = 32'd0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("rst_strobes", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
      check_val("rst_pending", {16'd0, pending}, 32'd0);
    end
    check_val("rst_data", rd_in | pc_in | cpsr_in | {28'd0, write_rd}, 32'd0);
    @(negedge clk); reset = 1'b1; #1;
    check_val("rel_mem_ready", {31'd0, mem_ready}, 32'd1);
    check_val("rel_alu_ready", {31'd0, alu_ready}, 32'd1);

    // single ALU write r3=42
    alu_offer(4'd3, 32'd42, 1'b0, 32'd0);
    step();
    check_val("r3_pending_set", {31'd0, pending[3]}, 32'd1);
    alu_valid = 1'b0;
    step();
    check_val("r3_strobe", {27'd0, rd_we, write_rd}, {27'd0, 1'b1, 4'd3});
    check_val("r3_data", rd_in, 32'd42);
    step();
    check_val("r3_strobe_drop", {31'd0, rd_we}, 32'd0);
    check_val("r3_pending_clr", {31'd0, pending[3]}, 32'd0);

    // same-cycle mem r1=7 and alu r1=9 with flags
    mem_valid = 1'b1; mem_rd = 4'd1; mem_data = 32'd7;
    alu_offer(4'd1, 32'd9, 1'b1, 32'h6000_0000);
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    step();
    check_val("dual_first", {cpsr_we, rd_we, write_rd, rd_in[25:0]}, {1'b0, 1'b1, 4'd1, 26'd7});
    step();
    check_val("dual_second", {cpsr_we, rd_we, write_rd, rd_in[25:0]}, {1'b1, 1'b1, 4'd1, 26'd9});
    check_val("dual_cpsr", cpsr_in, 32'h6000_0000);

    // pc write
    alu_offer(4'd15, 32'h100, 1'b0, 32'd0);
    step();
    alu_valid = 1'b0;
    step();
    check_val("pc_route", {30'd0, pc_we, rd_we}, {30'd0, 1'b1, 1'b0});
    check_val("pc_data", pc_in, 32'h100);
    idle(2);

    // fill: mem writes even regs, alu odd regs, each held until accepted
    mi = 0; ai = 0; cyc = 0; saw_stall = 1'b0;
    while ((mi < 4 || ai < 4) && cyc < 100) begin
      mem_valid = (mi < 4); mem_rd = 4'(2 * mi); mem_data = 32'hA000 + 32'(2 * mi);
      alu_valid = (ai < 4); alu_rd_en = 1'b1; alu_rd = 4'(2 * ai + 1);
      alu_data = 32'hA000 + 32'(2 * ai + 1); alu_cpsr_en = 1'b0;
      step();
      if (alu_valid && !seen_alu_ready) saw_stall = 1'b1;
      if (mem_acc) mi++;
      if (alu_acc) ai++;
      cyc++;
    end
    check_val("fill_done", {30'd0, mi == 4, ai == 4}, 32'd3);
    check_val("fill_stall", {31'd0, saw_stall}, 32'd1);
    idle(8);
    for (int r = 0; r < 8; r++) check_val("fill_readback", rf_dut[r], 32'hA000 + 32'(r));

    // flush with three entries queued
    mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 32'h44;
    alu_offer(4'd5, 32'h55, 1'b0, 32'd0);
    step();
    mem_rd = 4'd6; mem_data = 32'h66; alu_rd = 4'd7; alu_data = 32'h77;
    step();
    check_val("flush_depth", 32'(q.size()), 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    check_val("flush_pending", {16'd0, pending}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("flush_quiet", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
    end
    check_val("flush_ready", {30'd0, mem_ready, alu_ready}, 32'd3);

    // random traffic with legal hold behaviour
    for (int c = 0; c < 400; c++) begin
      if (!(mem_valid && !mem_acc)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd = 4'($urandom_range(0, 15));
        mem_data = $urandom;
      end
      if (!(alu_valid && !alu_acc)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd_en = ($urandom_range(0, 3) != 0);
        alu_rd = 4'($urandom_range(0, 15));
        alu_data = $urandom;
        alu_cpsr_en = ($urandom_range(0, 1) != 0);
        alu_cpsr = $urandom;
      end
      flush = ($urandom_range(0, 29) == 0);
      step();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
